game_flow_controller: RTL
=========================

# game_flow_controller

Sequences the keyboard-driven game flow. It consumes the byte stream from `PS2_Controller` and walks through speed select, difficulty select, ready, run and game over. It latches the player's selections, runs the round countdown timer, and exports a state code for the seven-segment display path (`Hexadecimal_To_Seven_Segment`). It sits between `PS2_Controller` and the game datapath, and is the only block that decides when a round starts and ends.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency; sets the 1 s tick period.
- `ROUND_SECONDS`, default 30: round length in seconds; range 1..255.
- `CLOCK_50` in 1: system clock; all logic on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low (driven from `KEY[0]`).
- `scan_code` in 8: received PS/2 byte (`received_data`).
- `scan_valid` in 1: one-cycle strobe qualifying `scan_code` (`received_data_en`).
- `game_over_in` in 1: level from game logic; player lost; sampled only in RUN.
- `state_code` out 8: 8'h01..8'h07 for SELECT_SPEED..OVER; feeds HEX0/HEX1.
- `speed_sel` out 2: latched speed, 1..3; 0 = never selected.
- `difficulty_sel` out 2: latched difficulty, 1..3; 0 = never selected.
- `game_run` out 1: high exactly while in RUN.
- `game_start` out 1: one-cycle pulse on the READY->RUN transition.
- `time_left` out 8: remaining seconds; meaningful in RUN and OVER.
- `round_won` out 1: set on entering OVER by timer expiry; cleared on entering OVER by loss and on leaving OVER.

## Operation
- **Prefix tracking.** 8'hF0 sets `brk`. 8'hE0 sets `ext`. Any other valid byte is a key event, with break = `brk` and extended = `ext`; both flags clear after that byte.
- **Extended events** are ignored entirely.
- **Digit keys:** 8'h16→1, 8'h1E→2, 8'h26→3. Space = 8'h29. Esc = 8'h76.
- **States** (`state_code` value):
  - SELECT_SPEED (1): digit make → latch `speed_sel`, store the key in `pend_key`, go to SPEED_REL.
  - SPEED_REL (2): break of `pend_key` → SELECT_DIFF. Typematic repeat makes are ignored.
  - SELECT_DIFF (3): digit make → latch `difficulty_sel`, store `pend_key`, go to DIFF_REL.
  - DIFF_REL (4): break of `pend_key` → READY.
  - READY (5): Space make → RUN. Load `time_left` = ROUND_SECONDS and clear the tick divider.
  - RUN (6): on each tick, decrement `time_left`. A tick when `time_left` = 1 sets it to 0 and goes to OVER with `round_won`=1. `game_over_in`=1 goes to OVER with `round_won`=0 and freezes `time_left`.
  - OVER (7): any non-extended make except Esc → SELECT_SPEED. Break codes are ignored.
- **Esc make** from any state → SELECT_SPEED; selections are kept. Esc in SELECT_SPEED is a no-op.
- **Non-matching bytes** are ignored in every state.
- **Selections** persist until overwritten; they are never cleared except by reset.

## Timing
- **Reset values:** state SELECT_SPEED, `state_code` 8'h01, `speed_sel`/`difficulty_sel` 0, `game_run` 0, `game_start` 0, `time_left` 0, `round_won` 0, `brk`/`ext` 0, divider 0.
- **Latency:** a `scan_valid` in cycle N changes state and all outputs at the edge ending cycle N, so they are visible in cycle N+1. `state_code` is a registered output.
- **Divider** counts 0..CLK_HZ-1 in RUN only. The tick fires at terminal count, so the first decrement comes CLK_HZ cycles after `game_start`.
- **Same-cycle priority in RUN:** Esc > `game_over_in` > tick expiry.
  - Expiry and `game_over_in` together → loss, `time_left` holds 1.
- **Prefix bytes** never cause transitions; an F0 arriving in the same state simply arms `brk`.
- **Reset mid-round** drops straight to reset values, with no `game_start` or `round_won` glitch.

## Structure
- `game_flow_pkg` holds:
  - the state enum with `state_code` encodings;
  - scancode constants: F0, E0, 16, 1E, 26, 29, 76;
  - a function mapping a digit scancode to 2'd1..3 (0 otherwise).
- Sub-module `sec_tick_gen` (params `CLK_HZ`; ports `CLOCK_50`, `resetn`, `clr`, `en`, `tick`). It produces a one-cycle `tick` every CLK_HZ enabled cycles. Benches override `CLK_HZ` to a small value such as 10.

## Test plan
- Reset, then the sequence 16, F0 16, 26, F0 26, 29 → `state_code` steps 1,2,3,4,5,6. Ends with `speed_sel`=1, `difficulty_sel`=3, one `game_start` pulse and `game_run`=1.
- In SPEED_REL after 1E: repeat 1E ×3, then F0 16 → stays at 2. Then F0 1E → 3.
- RUN with ROUND_SECONDS=3, CLK_HZ=10, no loss → `time_left` 3,2,1,0 at 10-cycle intervals. OVER with `round_won`=1 in the cycle after the third tick.
- RUN with `game_over_in` asserted on the same cycle as the final tick → OVER, `round_won`=0, `time_left`=1.
- E0 16 in SELECT_SPEED → no change. 76 in READY → `state_code` 8'h01 with selections retained.
- `resetn` low mid-RUN for 1 cycle → all outputs at reset values immediately, asynchronously; no `game_start` afterward until Space is pressed in READY.

Source files
------------

// File: rtl/game_flow_pkg.sv
// ============================================================================
// Module      : game_flow_pkg
// Description : Shared types and constants for the keyboard-driven game flow.
//               - state enum whose encoding is the exported state code
//               - PS/2 set-2 scancode constants used by the flow
//               - helper mapping digit scancodes 1..3 to their value
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_flow_pkg;

    // The enum value is exported directly as the display state code, so the
    // encoding must stay 1..7 in flow order.
    typedef enum logic [2:0] {
        ST_SELECT_SPEED = 3'd1,
        ST_SPEED_REL    = 3'd2,
        ST_SELECT_DIFF  = 3'd3,
        ST_DIFF_REL     = 3'd4,
        ST_READY        = 3'd5,
        ST_RUN          = 3'd6,
        ST_OVER         = 3'd7
    } state_e;

    localparam logic [7:0] c_SC_BREAK = 8'hF0;
    localparam logic [7:0] c_SC_EXT   = 8'hE0;
    localparam logic [7:0] c_SC_KEY1  = 8'h16;
    localparam logic [7:0] c_SC_KEY2  = 8'h1E;
    localparam logic [7:0] c_SC_KEY3  = 8'h26;
    localparam logic [7:0] c_SC_SPACE = 8'h29;
    localparam logic [7:0] c_SC_ESC   = 8'h76;

    // Digit scancode -> 2'd1..3; any other code -> 2'd0.
    function automatic logic [1:0] digit_value(input logic [7:0] code);
        logic [1:0] val;
        val = 2'd0;
        case (code)
            c_SC_KEY1: val = 2'd1;
            c_SC_KEY2: val = 2'd2;
            c_SC_KEY3: val = 2'd3;
            default:   val = 2'd0;
        endcase
        return val;
    endfunction

endpackage : game_flow_pkg

`default_nettype wire

// File: rtl/game_flow_controller_if.sv
// ============================================================================
// Module      : game_flow_controller_if
// Description : Signal bundle between the keyboard/game side and the game
//               flow controller.
//   master : drives scan_code, scan_valid, game_over_in; observes outputs
//   slave  : the controller; consumes inputs, drives state_code, speed_sel,
//            difficulty_sel, game_run, game_start, time_left, round_won
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_flow_controller_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       game_over_in;
    logic [7:0] state_code;
    logic [1:0] speed_sel;
    logic [1:0] difficulty_sel;
    logic       game_run;
    logic       game_start;
    logic [7:0] time_left;
    logic       round_won;

    modport master (
        output scan_code, scan_valid, game_over_in,
        input  state_code, speed_sel, difficulty_sel,
               game_run, game_start, time_left, round_won
    );

    modport slave (
        input  scan_code, scan_valid, game_over_in,
        output state_code, speed_sel, difficulty_sel,
               game_run, game_start, time_left, round_won
    );
endinterface : game_flow_controller_if

`default_nettype wire

// File: rtl/game_flow_controller_sec_tick_gen.sv
// ============================================================================
// Module      : sec_tick_gen
// Description : One-second tick generator. Counts enabled cycles 0..CLK_HZ-1
//               and pulses tick for one cycle at terminal count.
//   CLOCK_50 : clock          resetn : async active-low reset
//   clr      : sync counter clear (wins over en)
//   en       : count enable   tick   : one-cycle pulse at terminal count
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sec_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  wire logic CLOCK_50,
    input  wire logic resetn,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);

    localparam int                   c_CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_CNT_W-1:0]   c_TERM  = c_CNT_W'(CLK_HZ - 1);
    localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_TERM) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign tick = en && !clr && (r_cnt == c_TERM);

endmodule : sec_tick_gen

`default_nettype wire

// File: rtl/game_flow_controller.sv
// ============================================================================
// Module      : game_flow_controller
// Description : Keyboard-driven game flow sequencer. Decodes PS/2 prefix
//               bytes, walks SELECT_SPEED -> SPEED_REL -> SELECT_DIFF ->
//               DIFF_REL -> READY -> RUN -> OVER, latches selections and
//               runs the round countdown.
//   CLOCK_50 : clock           resetn : async active-low reset
//   bus      : slave side of game_flow_controller_if
//              (scan_code/scan_valid/game_over_in in; state_code, speed_sel,
//               difficulty_sel, game_run, game_start, time_left, round_won out)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int ROUND_SECONDS = 30
) (
    input  wire logic               CLOCK_50,
    input  wire logic               resetn,
    game_flow_controller_if.slave   bus
);

    localparam logic [7:0] c_ROUND_LOAD = 8'(ROUND_SECONDS);

    state_e     r_state;
    logic       r_brk;
    logic       r_ext;
    logic [7:0] r_pend_key;
    logic [1:0] r_speed;
    logic [1:0] r_diff;
    logic       r_game_run;
    logic       r_game_start;
    logic [7:0] r_time_left;
    logic       r_round_won;

    logic       w_is_break_byte;
    logic       w_is_ext_byte;
    logic       w_key_evt;
    logic       w_make;
    logic       w_release;
    logic       w_esc;
    logic [1:0] w_digit;
    logic       w_is_digit;
    logic       w_pend_release;
    logic       w_start;
    logic       w_run_en;
    logic       w_tick;

    // ------------------------------------------------------------------
    // Byte classification. A key event is any valid byte that is not a
    // prefix; it consumes the prefix flags armed before it. Extended
    // events never produce make/release so they are ignored everywhere.
    // ------------------------------------------------------------------
    assign w_is_break_byte = bus.scan_valid && (bus.scan_code == c_SC_BREAK);
    assign w_is_ext_byte   = bus.scan_valid && (bus.scan_code == c_SC_EXT);
    assign w_key_evt       = bus.scan_valid && !w_is_break_byte && !w_is_ext_byte;
    assign w_make          = w_key_evt && !r_ext && !r_brk;
    assign w_release       = w_key_evt && !r_ext &&  r_brk;
    assign w_esc           = w_make && (bus.scan_code == c_SC_ESC);
    assign w_digit         = digit_value(bus.scan_code);
    assign w_is_digit      = (w_digit != 2'd0);
    assign w_pend_release  = w_release && (bus.scan_code == r_pend_key);

    // Esc outranks Space, so a start cannot coincide with an abort.
    assign w_start  = (r_state == ST_READY) && w_make && (bus.scan_code == c_SC_SPACE);
    assign w_run_en = (r_state == ST_RUN);

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clr      (w_start),
        .en       (w_run_en),
        .tick     (w_tick)
    );

    // ------------------------------------------------------------------
    // Flow FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_SELECT_SPEED;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_pend_key   <= 8'h00;
            r_speed      <= 2'd0;
            r_diff       <= 2'd0;
            r_game_run   <= 1'b0;
            r_game_start <= 1'b0;
            r_time_left  <= 8'd0;
            r_round_won  <= 1'b0;
        end else begin
            r_game_start <= 1'b0;

            // Prefix tracking runs independently of the flow state.
            if (w_is_break_byte) begin
                r_brk <= 1'b1;
            end else if (w_is_ext_byte) begin
                r_ext <= 1'b1;
            end else if (w_key_evt) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end

            // Esc aborts to speed selection from anywhere; selections stay.
            // round_won can only be set in OVER, so clearing it here covers
            // the "leaving OVER" case.
            if (w_esc && (r_state != ST_SELECT_SPEED)) begin
                r_state     <= ST_SELECT_SPEED;
                r_game_run  <= 1'b0;
                r_round_won <= 1'b0;
            end else begin
                case (r_state)
                    ST_SELECT_SPEED: begin
                        if (w_make && w_is_digit) begin
                            r_speed    <= w_digit;
                            r_pend_key <= bus.scan_code;
                            r_state    <= ST_SPEED_REL;
                        end
                    end
                    ST_SPEED_REL: begin
                        // Typematic repeats are makes, so only the release
                        // of the chosen key advances.
                        if (w_pend_release) begin
                            r_state <= ST_SELECT_DIFF;
                        end
                    end
                    ST_SELECT_DIFF: begin
                        if (w_make && w_is_digit) begin
                            r_diff     <= w_digit;
                            r_pend_key <= bus.scan_code;
                            r_state    <= ST_DIFF_REL;
                        end
                    end
                    ST_DIFF_REL: begin
                        if (w_pend_release) begin
                            r_state <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (w_start) begin
                            r_state      <= ST_RUN;
                            r_time_left  <= c_ROUND_LOAD;
                            r_game_run   <= 1'b1;
                            r_game_start <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // A loss beats a coinciding expiry and freezes time.
                        if (bus.game_over_in) begin
                            r_state     <= ST_OVER;
                            r_round_won <= 1'b0;
                            r_game_run  <= 1'b0;
                        end else if (w_tick) begin
                            if (r_time_left == 8'd1) begin
                                r_time_left <= 8'd0;
                                r_state     <= ST_OVER;
                                r_round_won <= 1'b1;
                                r_game_run  <= 1'b0;
                            end else begin
                                r_time_left <= r_time_left - 8'd1;
                            end
                        end
                    end
                    ST_OVER: begin
                        if (w_make) begin
                            r_state     <= ST_SELECT_SPEED;
                            r_round_won <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_SELECT_SPEED;
                    end
                endcase
            end
        end
    end

    assign bus.state_code     = {5'd0, r_state};
    assign bus.speed_sel      = r_speed;
    assign bus.difficulty_sel = r_diff;
    assign bus.game_run       = r_game_run;
    assign bus.game_start     = r_game_start;
    assign bus.time_left      = r_time_left;
    assign bus.round_won      = r_round_won;

endmodule : game_flow_controller

`default_nettype wire
